// File: rtl/arb4_rr_sched.sv
// Four-requester scheduler with registered one-hot grant and owner index.
// Optional ownership watchdog is compiled in with `define ARB_TIMEOUT_EN.
module arb4_rr_sched #(
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] scan_base;
  logic [1:0] cand;
  logic [1:0] winner;
  logic [3:0] eligible;
  logic [3:0] block_mask;
  logic       owner_req;
  logic       expire;
  logic       revoke;

  assign owner_req = req[gnt_idx];
  assign revoke    = (state == GRANT) && owner_req && expire;

  // Reverse scan so the lowest offset from the base is the last (winning) assignment.
  always_comb begin
    scan_base = (ROUND_ROBIN != 0) ? ptr : 2'd0;
    eligible  = req & ~block_mask;
    winner    = scan_base;
    cand      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = scan_base + 2'(i);
      if (eligible[cand]) winner = cand;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;

  assign expire = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if (state == IDLE) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  // A blocked requester must be seen low once before it can compete again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_mask <= 4'b0000;
    end else begin
      block_mask <= (block_mask & req) | (revoke ? (4'b0001 << gnt_idx) : 4'b0000);
    end
  end
`else
  localparam int unused_max_hold = MAX_HOLD;

  assign expire     = 1'b0;
  assign block_mask = 4'b0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            state     <= GRANT;
            gnt       <= 4'b0001 << winner;
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
          end
        end
        GRANT: begin
          // gnt_idx is left alone on release; it only matters while gnt_valid is high.
          if (!owner_req || revoke) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            timeout   <= revoke;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb4_rr_sched.sv
// Bench for arb4_rr_sched: one rotating-priority and one fixed-priority instance.
// Vector table plus hand sequences; expectations flow through a scoreboard queue.
module tb_arb4_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_rr = 4'b0000;
  logic [3:0] req_fx = 4'b0000;
  logic [3:0] gnt_rr, gnt_fx;
  logic [1:0] idx_rr, idx_fx;
  logic       valid_rr, valid_fx;
  logic       to_rr, to_fx;

  always #5 clk = ~clk;

  arb4_rr_sched #(.ROUND_ROBIN(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_rr),
    .gnt(gnt_rr), .gnt_idx(idx_rr), .gnt_valid(valid_rr), .timeout(to_rr)
  );

  arb4_rr_sched #(.ROUND_ROBIN(0), .MAX_HOLD(4)) u_fx (
    .clk(clk), .rst_n(rst_n), .req(req_fx),
    .gnt(gnt_fx), .gnt_idx(idx_fx), .gnt_valid(valid_fx), .timeout(to_fx)
  );

  typedef struct {
    logic [3:0] req_rr;
    logic [3:0] req_fx;
    logic [3:0] exp_rr;
    logic [3:0] exp_fx;
    logic       exp_to;
  } vec_t;

  typedef struct {
    logic [3:0] rr;
    logic [3:0] fx;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic [1:0] idx_rr_exp = 2'd0;
  logic [1:0] idx_fx_exp = 2'd0;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests at the falling edge, check results at the next falling edge.
  task automatic step(input string tag, input logic [3:0] rr, input logic [3:0] fx,
                      input logic [3:0] er, input logic [3:0] ef, input logic eto);
    exp_t e;
    req_rr = rr;
    req_fx = fx;
    e.rr = er;
    e.fx = ef;
    e.to = eto;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    if (e.rr != 4'b0000) idx_rr_exp = enc(e.rr);
    if (e.fx != 4'b0000) idx_fx_exp = enc(e.fx);
    chk({tag, " gnt_rr"},   8'(gnt_rr),   8'(e.rr));
    chk({tag, " valid_rr"}, 8'(valid_rr), 8'(|e.rr));
    chk({tag, " idx_rr"},   8'(idx_rr),   8'(idx_rr_exp));
    chk({tag, " to_rr"},    8'(to_rr),    8'(e.to));
    chk({tag, " gnt_fx"},   8'(gnt_fx),   8'(e.fx));
    chk({tag, " valid_fx"}, 8'(valid_fx), 8'(|e.fx));
    chk({tag, " idx_fx"},   8'(idx_fx),   8'(idx_fx_exp));
    chk({tag, " to_fx"},    8'(to_fx),    8'(1'b0));
  endtask

  initial begin
    logic [3:0] own;

    // Basic grant, release with bubble, next owner.
    vecs.push_back('{4'b1010, 4'b1010, 4'b0010, 4'b0010, 1'b0});
    vecs.push_back('{4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b0});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    // All requesting; owner drops for one cycle after three granted cycles.
    for (int k = 0; k < 5; k++) begin
      own = 4'(1 << (k % 4));
      for (int c = 0; c < 3; c++)
        vecs.push_back('{4'b1111, 4'b1111, own, 4'b0001, 1'b0});
      vecs.push_back('{4'b1111 & ~own, 4'b1110, 4'b0000, 4'b0000, 1'b0});
    end
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    // Pointer wrap and mixed simultaneous requests.
    vecs.push_back('{4'b0101, 4'b0101, 4'b0100, 4'b0001, 1'b0});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0011, 4'b0011, 4'b0001, 4'b0001, 1'b0});
    vecs.push_back('{4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b0});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});

    repeat (2) @(negedge clk);
    chk("rst gnt_rr",   8'(gnt_rr),   8'h0);
    chk("rst valid_rr", 8'(valid_rr), 8'h0);
    chk("rst idx_rr",   8'(idx_rr),   8'h0);
    chk("rst to_rr",    8'(to_rr),    8'h0);
    chk("rst gnt_fx",   8'(gnt_fx),   8'h0);
    chk("rst valid_fx", 8'(valid_fx), 8'h0);
    rst_n = 1'b1;

    foreach (vecs[i])
      step($sformatf("v%0d", i), vecs[i].req_rr, vecs[i].req_fx,
           vecs[i].exp_rr, vecs[i].exp_fx, vecs[i].exp_to);

    // Asynchronous reset while requester 2 owns the resource.
    step("ar0", 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst gnt_rr",   8'(gnt_rr),   8'h0);
    chk("async_rst valid_rr", 8'(valid_rr), 8'h0);
    chk("async_rst idx_rr",   8'(idx_rr),   8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idx_rr_exp = 2'd0;
    idx_fx_exp = 2'd0;
    step("ar1", 4'b1010, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    step("ar2", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step("ar3", 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    step("ar4", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    step("to0",  4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    step("to1",  4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    step("to2",  4'b0101, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    step("to3",  4'b0101, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    step("to4",  4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("to5",  4'b0101, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    step("to6",  4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step("to7",  4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step("to8",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step("to9",  4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    step("to10", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // Release on the expiry edge is an ordinary release.
    for (int c = 0; c < 4; c++)
      step($sformatf("ex%0d", c), 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    step("ex4", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step("ex5", 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    step("ex6", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
`else
    for (int c = 0; c < 8; c++)
      step($sformatf("hold%0d", c), 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    step("hold8", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
